power_switch_ack_model: RTL and testbench

Parametrised multi-channel model of power-switch cells for the simulation testharness. It generalises the fixed-latency switch-ack shift register used for the CPU, peripheral, memory-bank and external power domains. Each channel turns a power-gate request (`switch_ni`) into a delayed acknowledge (`ack_no`), with separate power-on and power-off latencies, a per-channel reset state, and abort of a request that reverses mid-ramp. It sits between the power manager's switch outputs and the switch-ack inputs of `core_v_mini_mcu`/external domains, replacing per-domain delay chains.

---
 rtl/power_switch_ack_model_if.sv | 24 ++
 rtl/power_switch_ack_model.sv | 131 +++++++++++++
 tb/tb_power_switch_ack_model.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/power_switch_ack_model_if.sv
// Switch request / acknowledge bundle between a power manager and the switch-cell model.
// All signals are active-low on the switch side, one bit per channel.
interface power_switch_ack_model_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] switch_ni;
    logic [NUM_CH-1:0] ack_no;
    logic [NUM_CH-1:0] busy_o;
    logic [NUM_CH-1:0] abort_o;

    modport master (
        output switch_ni,
        input  ack_no,
        input  busy_o,
        input  abort_o
    );

    modport slave (
        input  switch_ni,
        output ack_no,
        output busy_o,
        output abort_o
    );
endinterface

// File: rtl/power_switch_ack_model.sv
// Multi-channel power-switch cell model: each channel turns an active-low switch request
// into a delayed active-low acknowledge, with separate on/off latencies and ramp abort.
module power_switch_ack_model #(
    parameter int                NUM_CH      = 4,
    parameter int                ON_LATENCY  = 15,
    parameter int                OFF_LATENCY = 15,
    parameter logic [NUM_CH-1:0] RESET_ON    = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    power_switch_ack_model_if.slave  sw
);

    localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] ON_LOAD    = CW'(ON_LATENCY - 1);
    localparam logic [CW-1:0] OFF_LOAD   = CW'(OFF_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam bit            ON_DIRECT  = (ON_LATENCY == 1);
    localparam bit            OFF_DIRECT = (OFF_LATENCY == 1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RAMP_ON  = 2'd1,
        ST_ON       = 2'd2,
        ST_RAMP_OFF = 2'd3
    } state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam state_e RST_STATE = RESET_ON[i] ? ST_ON : ST_OFF;

        state_e        state_r;
        state_e        state_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_s;
        logic          ack_r;
        logic          ack_s;
        logic          busy_r;
        logic          busy_s;
        logic          abort_r;
        logic          abort_s;

        // Channel state, counter and registered outputs.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_r <= RST_STATE;
                cnt_r   <= '0;
                ack_r   <= ~RESET_ON[i];
                busy_r  <= 1'b0;
                abort_r <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                ack_r   <= ack_s;
                busy_r  <= busy_s;
                abort_r <= abort_s;
            end
        end

        // Next state; a reversal during a ramp wins over ramp completion, so ack never glitches.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            abort_s = 1'b0;
            case (state_r)
                ST_OFF: begin
                    if (!sw.switch_ni[i]) begin
                        if (ON_DIRECT) begin
                            state_s = ST_ON;
                        end else begin
                            state_s = ST_RAMP_ON;
                            cnt_s   = ON_LOAD;
                        end
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_ON: begin
                    if (sw.switch_ni[i]) begin
                        if (OFF_DIRECT) begin
                            state_s = ST_OFF;
                        end else begin
                            state_s = ST_RAMP_OFF;
                            cnt_s   = OFF_LOAD;
                        end
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_RAMP_ON: begin
                    if (sw.switch_ni[i]) begin
                        state_s = ST_OFF;
                        cnt_s   = '0;
                        abort_s = 1'b1;
                    end else if (cnt_r == CNT_ONE) begin
                        state_s = ST_ON;
                        cnt_s   = '0;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_RAMP_OFF: begin
                    if (!sw.switch_ni[i]) begin
                        state_s = ST_ON;
                        cnt_s   = '0;
                        abort_s = 1'b1;
                    end else if (cnt_r == CNT_ONE) begin
                        state_s = ST_OFF;
                        cnt_s   = '0;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = RST_STATE;
                    cnt_s   = '0;
                end
            endcase

            // The domain stays powered while ramping down, so ack is low in ON and RAMP_OFF.
            ack_s  = ~((state_s == ST_ON) || (state_s == ST_RAMP_OFF));
            busy_s = (state_s == ST_RAMP_ON) || (state_s == ST_RAMP_OFF);
        end

        assign sw.ack_no[i]  = ack_r;
        assign sw.busy_o[i]  = busy_r;
        assign sw.abort_o[i] = abort_r;
    end

endmodule

// File: tb/tb_power_switch_ack_model.sv
// Directed bench for power_switch_ack_model: three builds (15/15 with mixed reset state,
// asymmetric 3/7, and single-cycle latency) driven from one shared clock and reset.
module tb_power_switch_ack_model;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    power_switch_ack_model_if #(.NUM_CH(4)) ifa ();
    power_switch_ack_model_if #(.NUM_CH(4)) ifb ();
    power_switch_ack_model_if #(.NUM_CH(4)) ifc ();

    power_switch_ack_model #(
        .NUM_CH(4), .ON_LATENCY(15), .OFF_LATENCY(15), .RESET_ON(4'b0101)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .sw(ifa)
    );

    power_switch_ack_model #(
        .NUM_CH(4), .ON_LATENCY(3), .OFF_LATENCY(7), .RESET_ON(4'b0000)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .sw(ifb)
    );

    power_switch_ack_model #(
        .NUM_CH(4), .ON_LATENCY(1), .OFF_LATENCY(1), .RESET_ON(4'b0000)
    ) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .sw(ifc)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_ack;
    logic [3:0] exp_busy;
    logic [3:0] exp_abort;
    logic [3:0] prev;
    logic [3:0] l1_vecs [0:5];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        l1_vecs = '{4'b0000, 4'b1010, 4'b0101, 4'b0110, 4'b1001, 4'b1111};

        rst_n         = 1'b0;
        ifa.switch_ni = 4'b1010;
        ifb.switch_ni = 4'b1111;
        ifc.switch_ni = 4'b1111;
        tick(3);

        check_val("rst_ack_a",   ifa.ack_no,  32'h0000000a);
        check_val("rst_busy_a",  ifa.busy_o,  32'h0);
        check_val("rst_abort_a", ifa.abort_o, 32'h0);
        check_val("rst_ack_b",   ifb.ack_no,  32'h0000000f);
        check_val("rst_ack_c",   ifc.ack_no,  32'h0000000f);

        // Release with requests agreeing with the reset state: nothing may move.
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            check_val("hold_ack_a",  ifa.ack_no, 32'h0000000a);
            check_val("hold_busy_a", ifa.busy_o, 32'h0);
        end

        // Power-on of channel 1, 15-cycle latency.
        ifa.switch_ni = 4'b1000;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            exp_ack  = (e >= 15) ? 4'b1000 : 4'b1010;
            exp_busy = (e < 15)  ? 4'b0010 : 4'b0000;
            check_val("pon_ack",  ifa.ack_no, {28'd0, exp_ack});
            check_val("pon_busy", ifa.busy_o, {28'd0, exp_busy});
        end

        // Power-off of channel 2.
        ifa.switch_ni = 4'b1100;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            exp_ack  = (e >= 15) ? 4'b1100 : 4'b1000;
            exp_busy = (e < 15)  ? 4'b0100 : 4'b0000;
            check_val("poff_ack",  ifa.ack_no, {28'd0, exp_ack});
            check_val("poff_busy", ifa.busy_o, {28'd0, exp_busy});
        end

        // Channel 2 requested for 5 cycles, reversal sampled at edge 6.
        ifa.switch_ni = 4'b1000;
        for (int e = 1; e <= 20; e++) begin
            if (e == 6) ifa.switch_ni = 4'b1100;
            tick(1);
            exp_busy  = (e <= 5) ? 4'b0100 : 4'b0000;
            exp_abort = (e == 6) ? 4'b0100 : 4'b0000;
            check_val("abort_ack",   ifa.ack_no,  32'h0000000c);
            check_val("abort_busy",  ifa.busy_o,  {28'd0, exp_busy});
            check_val("abort_pulse", ifa.abort_o, {28'd0, exp_abort});
        end

        // All channels requested together; reversals at edges 3 (ch0), 10 (ch1), 6 (ch2).
        for (int e = 1; e <= 18; e++) begin
            if (e == 1)  ifa.switch_ni = 4'b0011;
            if (e == 3)  ifa.switch_ni[0] = 1'b0;
            if (e == 6)  ifa.switch_ni[2] = 1'b1;
            if (e == 10) ifa.switch_ni[1] = 1'b0;
            tick(1);
            exp_ack   = {(e >= 15) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0};
            exp_busy  = {(e <= 14), (e <= 5), (e <= 9), (e <= 2)};
            exp_abort = {1'b0, (e == 6), (e == 10), (e == 3)};
            check_val("indep_ack",   ifa.ack_no,  {28'd0, exp_ack});
            check_val("indep_busy",  ifa.busy_o,  {28'd0, exp_busy});
            check_val("indep_abort", ifa.abort_o, {28'd0, exp_abort});
        end

        // Return to the reset pattern: three channels ramp at once.
        ifa.switch_ni = 4'b1010;
        tick(14);
        check_val("realign_ack14",  ifa.ack_no, 32'h00000004);
        check_val("realign_busy14", ifa.busy_o, 32'h0000000e);
        tick(1);
        check_val("realign_ack15",  ifa.ack_no, 32'h0000000a);
        check_val("realign_busy15", ifa.busy_o, 32'h0);

        // Reset asserted during ramp cycle 7, request kept low through and after reset.
        ifa.switch_ni = 4'b1000;
        tick(7);
        check_val("mid_busy7", ifa.busy_o, 32'h00000002);
        check_val("mid_ack7",  ifa.ack_no, 32'h0000000a);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_ack",   ifa.ack_no,  32'h0000000a);
        check_val("async_rst_busy",  ifa.busy_o,  32'h0);
        check_val("async_rst_abort", ifa.abort_o, 32'h0);
        tick(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            exp_ack  = (e >= 15) ? 4'b1000 : 4'b1010;
            exp_busy = (e < 15)  ? 4'b0010 : 4'b0000;
            check_val("rerun_ack",  ifa.ack_no, {28'd0, exp_ack});
            check_val("rerun_busy", ifa.busy_o, {28'd0, exp_busy});
        end

        // Asymmetric build: on in 3, off in 7.
        ifb.switch_ni = 4'b1110;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            exp_ack  = (e >= 3) ? 4'b1110 : 4'b1111;
            exp_busy = (e < 3)  ? 4'b0001 : 4'b0000;
            check_val("asym_on_ack",  ifb.ack_no, {28'd0, exp_ack});
            check_val("asym_on_busy", ifb.busy_o, {28'd0, exp_busy});
        end
        ifb.switch_ni = 4'b1111;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            exp_ack  = (e >= 7) ? 4'b1111 : 4'b1110;
            exp_busy = (e < 7)  ? 4'b0001 : 4'b0000;
            check_val("asym_off_ack",  ifb.ack_no, {28'd0, exp_ack});
            check_val("asym_off_busy", ifb.busy_o, {28'd0, exp_busy});
        end

        // Two-cycle pulse against a 3-cycle on latency: reversal lands on the terminal edge.
        ifb.switch_ni = 4'b1110;
        tick(2);
        ifb.switch_ni = 4'b1111;
        tick(1);
        check_val("short_abort", ifb.abort_o, 32'h00000001);
        check_val("short_busy",  ifb.busy_o,  32'h0);
        check_val("short_ack",   ifb.ack_no,  32'h0000000f);
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            check_val("short_ack_after",   ifb.ack_no,  32'h0000000f);
            check_val("short_abort_after", ifb.abort_o, 32'h0);
        end

        // Latency-1 build behaves as a plain flop with no combinational path.
        prev = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            ifc.switch_ni = l1_vecs[k];
            #2;
            check_val("l1_nocomb", ifc.ack_no, {28'd0, prev});
            tick(1);
            check_val("l1_ack",   ifc.ack_no,  {28'd0, l1_vecs[k]});
            check_val("l1_busy",  ifc.busy_o,  32'h0);
            check_val("l1_abort", ifc.abort_o, 32'h0);
            prev = l1_vecs[k];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
